ifid_skid_stage: RTL and testbench

// Parametrised IF/ID pipeline stage for the 32-bit MIPS-style datapath. Sits between

---
 rtl/ifid_skid_stage.sv | 90 +++++++++
 tb/tb_ifid_skid_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ifid_skid_stage.sv
// ifid_skid_stage: IF/ID buffer of DEPTH {pc, instr} entries with valid/ready handshakes and flush.
// R/I/J fields are decoded and masked at push time, so the head drives decode straight from storage.
module ifid_skid_stage #(
    parameter int         PC_W   = 9,
    parameter int         DEPTH  = 2,
    parameter logic [5:0] JAL_OP = 6'b000011,
    parameter logic [5:0] J_OP   = 6'b000010
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [5:0]      opcode,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [15:0]     imm16,
    output logic [25:0]     addr26,
    output logic [1:0]      fmt
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 2 + 15 + 16 + 26 + PC_W + 32;

    logic [EW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_head, r_tail;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic            r_full;
    logic            w_push, w_pop;
    logic [5:0]      w_op;
    logic [1:0]      w_fmt;
    logic [EW-1:0]   w_entry, w_head;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_op  = in_instr[31:26];
    assign w_fmt = (w_op == 6'd0) ? 2'b00 : (w_op == JAL_OP || w_op == J_OP) ? 2'b10 : 2'b01;
    assign w_entry = {w_fmt,
                      (w_fmt != 2'b10) ? in_instr[25:16] : 10'd0,
                      (w_fmt == 2'b00) ? in_instr[15:11] : 5'd0,
                      (w_fmt == 2'b01) ? in_instr[15:0]  : 16'd0,
                      (w_fmt == 2'b10) ? in_instr[25:0]  : 26'd0,
                      in_pc, in_instr};

    // ready is registered full-flag, so there is no path from out_ready to in_ready
    assign in_ready  = ~r_full & ~reset;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        w_count_nxt = flush ? '0 : r_count + CW'(w_push) - CW'(w_pop);
        w_head      = out_valid ? r_mem[r_head] : '0;
    end

    assign {fmt, rs, rt, rd, imm16, addr26, out_pc, out_instr} = w_head;
    assign opcode = w_head[31:26];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            if (flush) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_tail] <= w_entry;
                    r_tail        <= f_next(r_tail);
                end
                if (w_pop) r_head <= f_next(r_head);
            end
        end
    end
endmodule

// File: tb/tb_ifid_skid_stage.sv
// tb_ifid_skid_stage: directed stimulus on DEPTH=2 and DEPTH=3 instances sharing one input stream.
// Each instance has a transaction queue of expected entries popped by its own negedge monitor.
module tb_ifid_skid_stage;
    typedef struct packed {
        logic [31:0] instr;
        logic [1:0]  fmt;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] adr;
    } vec_t;

    typedef struct {
        logic [8:0] pc;
        int         idx;
    } exp_t;

    localparam vec_t TBL [8] = '{
        '{32'h012A4020, 2'b00, 5'd9,  5'd10, 5'd8, 16'h0000, 26'h0},
        '{32'h0C000010, 2'b10, 5'd0,  5'd0,  5'd0, 16'h0000, 26'h10},
        '{32'h2128FFFF, 2'b01, 5'd9,  5'd8,  5'd0, 16'hFFFF, 26'h0},
        '{32'h08000100, 2'b10, 5'd0,  5'd0,  5'd0, 16'h0000, 26'h100},
        '{32'h8C430004, 2'b01, 5'd2,  5'd3,  5'd0, 16'h0004, 26'h0},
        '{32'h00851822, 2'b00, 5'd4,  5'd5,  5'd3, 16'h0000, 26'h0},
        '{32'hFFFFFFFF, 2'b01, 5'd31, 5'd31, 5'd0, 16'hFFFF, 26'h0},
        '{32'h03E00008, 2'b00, 5'd31, 5'd0,  5'd0, 16'h0000, 26'h0}
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [8:0]  in_pc = '0;
    logic [31:0] in_instr = '0;
    int          in_idx = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int D = g + 2;
        logic        ir, ov;
        logic [8:0]  opc;
        logic [31:0] oin;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] adr;
        logic [1:0]  fmt;
        exp_t        q[$];

        ifid_skid_stage #(.PC_W(9), .DEPTH(D)) dut (
            .clk(clk), .reset(reset), .flush(flush),
            .in_valid(in_valid), .in_ready(ir), .in_pc(in_pc), .in_instr(in_instr),
            .out_valid(ov), .out_ready(out_ready), .out_pc(opc), .out_instr(oin),
            .opcode(op), .rs(rs), .rt(rt), .rd(rd), .imm16(imm), .addr26(adr), .fmt(fmt)
        );

        always @(negedge clk) begin
            bit   pu, po;
            vec_t v;
            if (reset) begin
                chk($sformatf("d%0d rst_out_valid", D), {31'd0, ov}, 32'd0);
                chk($sformatf("d%0d rst_in_ready", D), {31'd0, ir}, 32'd0);
                chk($sformatf("d%0d rst_bus", D), {31'd0, |{opc, oin, op, rs, rt, rd, imm, adr, fmt}}, 32'd0);
                q.delete();
            end else begin
                chk($sformatf("d%0d in_ready", D), {31'd0, ir}, {31'd0, q.size() != D});
                chk($sformatf("d%0d out_valid", D), {31'd0, ov}, {31'd0, q.size() != 0});
                if (q.size() != 0) begin
                    v = TBL[q[0].idx];
                    chk($sformatf("d%0d pc", D), {23'd0, opc}, {23'd0, q[0].pc});
                    chk($sformatf("d%0d instr", D), oin, v.instr);
                    chk($sformatf("d%0d opcode", D), {26'd0, op}, {26'd0, v.instr[31:26]});
                    chk($sformatf("d%0d fmt", D), {30'd0, fmt}, {30'd0, v.fmt});
                    chk($sformatf("d%0d rs", D), {27'd0, rs}, {27'd0, v.rs});
                    chk($sformatf("d%0d rt", D), {27'd0, rt}, {27'd0, v.rt});
                    chk($sformatf("d%0d rd", D), {27'd0, rd}, {27'd0, v.rd});
                    chk($sformatf("d%0d imm16", D), {16'd0, imm}, {16'd0, v.imm});
                    chk($sformatf("d%0d addr26", D), {6'd0, adr}, {6'd0, v.adr});
                end else begin
                    chk($sformatf("d%0d bubble", D), {31'd0, |{opc, oin, op, rs, rt, rd, imm, adr, fmt}}, 32'd0);
                end
                if (flush) begin
                    q.delete();
                end else begin
                    po = (q.size() != 0) && out_ready;
                    pu = in_valid && (q.size() != D);
                    if (po) void'(q.pop_front());
                    if (pu) q.push_back('{in_pc, in_idx});
                end
            end
        end
    end

    task automatic cyc(input bit v, input int idx, input logic [8:0] pc, input bit rdy, input bit fl);
        in_valid  = v;
        in_idx    = idx;
        in_instr  = TBL[idx].instr;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        // T1: two entries buffered, then asynchronous reset
        cyc(1, 0, 9'd0, 0, 0);
        cyc(1, 1, 9'd4, 0, 0);
        cyc(0, 0, 9'd0, 0, 0);
        reset = 1'b1;
        cyc(0, 0, 9'd0, 0, 0);
        reset = 1'b0;
        cyc(0, 0, 9'd0, 1, 0);
        // T2: streaming with out_ready held high
        cyc(1, 0, 9'd4, 1, 0);
        cyc(1, 5, 9'd8, 1, 0);
        cyc(1, 7, 9'd12, 1, 0);
        cyc(0, 0, 9'd0, 1, 0);
        cyc(0, 0, 9'd0, 1, 0);
        // T3: backpressure, third entry held until space frees up
        cyc(1, 2, 9'd0, 0, 0);
        cyc(1, 4, 9'd4, 0, 0);
        cyc(1, 6, 9'd8, 0, 0);
        cyc(1, 6, 9'd8, 0, 0);
        cyc(1, 6, 9'd8, 1, 0);
        cyc(1, 6, 9'd8, 1, 0);
        repeat (4) cyc(0, 0, 9'd0, 1, 0);
        // T4: J and I formats
        cyc(1, 1, 9'd16, 1, 0);
        cyc(1, 2, 9'd20, 1, 0);
        cyc(1, 3, 9'd24, 1, 0);
        repeat (2) cyc(0, 0, 9'd0, 1, 0);
        // T5: flush a full buffer while an input is presented
        cyc(1, 3, 9'd24, 0, 0);
        cyc(1, 4, 9'd28, 0, 0);
        cyc(1, 0, 9'd30, 0, 0);
        cyc(1, 5, 9'd32, 1, 1);
        cyc(0, 0, 9'd0, 0, 0);
        cyc(1, 6, 9'd36, 1, 0);
        repeat (2) cyc(0, 0, 9'd0, 1, 0);
        // T6: pointer wrap under a mixed ready pattern
        for (int i = 0; i < 10; i++) cyc(1, i % 8, 9'(40 + 4 * i), (i % 4) < 2, 0);
        repeat (5) cyc(0, 0, 9'd0, 1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
